hdlc_rx_frame_chk: RTL

- Sits directly downstream of the HDLC receive deframer. Consumes its de-stuffed byte stream and end/abort strobes, already retimed into the clk_100m domain.
- Checks CRC-16/X.25 FCS, length limits and buffer availability, then writes good frames into a two-bank ping-pong region of the rx DPRAM.
- Raises a stretched interrupt to the DSP (GPIO line). The DSP reads payload over EMIF and releases each bank with an ack pulse.

---
 rtl/hdlc_rx_frame_chk_pkg.sv | 12 +
 rtl/hdlc_rx_frame_chk_if.sv | 9 +
 rtl/hdlc_rx_frame_chk_crc.sv | 15 +
 rtl/hdlc_rx_frame_chk.sv | 110 +++++++++++
 4 files changed

// File: rtl/hdlc_rx_frame_chk_pkg.sv
// hdlc_pkg: shared constants, FSM encoding and helpers for the HDLC receive frame checker.
package hdlc_pkg;
  localparam logic [15:0] FCS_INIT = 16'hFFFF;
  localparam logic [15:0] FCS_POLY_R = 16'h8408;
  localparam logic [15:0] FCS_GOOD = 16'hF0B8;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_MAX_LEN = 512;
  typedef enum logic [1:0] {IDLE, RECV, DISCARD, CHECK} rx_state_e;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v + {15'd0, v != 16'hFFFF};
  endfunction
endpackage

// File: rtl/hdlc_rx_frame_chk_if.sv
// hdlc_rx_frame_chk_if: de-stuffed byte stream and end/abort strobes from the deframer.
interface hdlc_rx_frame_chk_if;
  logic rx_byte_vld;
  logic [7:0] rx_byte;
  logic rx_frame_end;
  logic rx_abort;
  modport master(output rx_byte_vld, rx_byte, rx_frame_end, rx_abort);
  modport slave(input rx_byte_vld, rx_byte, rx_frame_end, rx_abort);
endinterface

// File: rtl/hdlc_rx_frame_chk_crc.sv
// crc16_x25_byte: combinational CRC-16/X.25 update by one byte, LSB first.
module crc16_x25_byte
  import hdlc_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);
  logic [15:0] c;
  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ FCS_POLY_R : c >> 1;
    crc_out = c;
  end
endmodule

// File: rtl/hdlc_rx_frame_chk.sv
// hdlc_rx_frame_chk: FCS/length check of received HDLC frames, ping-pong write to rx DPRAM,
// stretched frame-ready interrupt to the DSP.
module hdlc_rx_frame_chk
  import hdlc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int MIN_LEN = 4,
  parameter int IRQ_CYC = 200
) (
  input  logic                clk_100m,
  input  logic                rst_n,
  hdlc_rx_frame_chk_if.slave  rx,
  input  logic [1:0]          bank_ack,
  output logic                ram_we,
  output logic [ADDR_W:0]     ram_addr,
  output logic [7:0]          ram_wdata,
  output logic [1:0]          bank_full,
  output logic [ADDR_W:0]     sts_len0,
  output logic [ADDR_W:0]     sts_len1,
  output logic [15:0]         err_cnt,
  output logic [15:0]         drop_cnt,
  output logic                irq
);
  localparam int IW = $clog2(IRQ_CYC + 1);
  localparam int IRQ_M1 = IRQ_CYC - 1;
  localparam logic [IW-1:0] IRQ_LD = IRQ_M1[IW-1:0];
  localparam logic [ADDR_W:0] MAX_C = MAX_LEN[ADDR_W:0];
  localparam logic [ADDR_W:0] MIN_C = MIN_LEN[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE = 1;
  localparam logic [ADDR_W:0] TWO = 2;
  rx_state_e state;
  logic next_bank;
  logic [ADDR_W:0] count;
  logic [15:0] crc, crc_nxt;
  logic [IW-1:0] irq_cnt;
  logic good;
  assign good = count >= MIN_C && crc == FCS_GOOD;
  crc16_x25_byte u_crc (
    .crc_in (state == IDLE ? FCS_INIT : crc),
    .data   (rx.rx_byte),
    .crc_out(crc_nxt)
  );
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      next_bank <= 1'b0;
      count <= '0;
      crc <= FCS_INIT;
      irq_cnt <= '0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      bank_full <= '0;
      sts_len0 <= '0;
      sts_len1 <= '0;
      err_cnt <= '0;
      drop_cnt <= '0;
      irq <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      bank_full <= bank_full & ~bank_ack;
      if (irq_cnt != '0) irq_cnt <= irq_cnt - 1'b1;
      else irq <= 1'b0;
      case (state)
        IDLE: if (rx.rx_byte_vld && !rx.rx_abort) begin
          if (bank_full[next_bank]) begin
            drop_cnt <= sat_inc(drop_cnt);
            state <= rx.rx_frame_end ? IDLE : DISCARD;
          end else begin
            ram_we <= 1'b1;
            ram_addr <= {next_bank, {ADDR_W{1'b0}}};
            ram_wdata <= rx.rx_byte;
            count <= ONE;
            crc <= crc_nxt;
            state <= rx.rx_frame_end ? CHECK : RECV;
          end
        end
        RECV: if (rx.rx_abort) state <= IDLE;
        else if (rx.rx_byte_vld && count == MAX_C) begin
          err_cnt <= sat_inc(err_cnt);
          state <= rx.rx_frame_end ? IDLE : DISCARD;
        end else begin
          if (rx.rx_byte_vld) begin
            ram_we <= 1'b1;
            ram_addr <= {next_bank, count[ADDR_W-1:0]};
            ram_wdata <= rx.rx_byte;
            count <= count + 1'b1;
            crc <= crc_nxt;
          end
          if (rx.rx_frame_end) state <= CHECK;
        end
        DISCARD: if (rx.rx_frame_end || rx.rx_abort) state <= IDLE;
        CHECK: begin
          // the bit-select set overrides the ack-clear above only for the committed bank
          if (good) begin
            bank_full[next_bank] <= 1'b1;
            if (next_bank) sts_len1 <= count - TWO;
            else sts_len0 <= count - TWO;
            next_bank <= ~next_bank;
            irq <= 1'b1;
            irq_cnt <= IRQ_LD;
          end else err_cnt <= sat_inc(err_cnt);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
